// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the PC sequencer.
// Defines the sequencer states, the decoded op_class codes and the
// PC_select encodings driven to the address generator.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    RST    = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_e;

  // Decoded instruction classes presented on op_class
  localparam logic [2:0] OP_SEQ    = 3'b000;
  localparam logic [2:0] OP_BR_REL = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;
  localparam logic [2:0] OP_HALT   = 3'b111;

  // Address-generator source select
  localparam logic [1:0] PCSEL_RA   = 2'b00;
  localparam logic [1:0] PCSEL_NEXT = 2'b01;
  localparam logic [1:0] PCSEL_ABS  = 2'b10;

  // True for the op_class codes the sequencer knows how to execute
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_SEQ)  || (op == OP_BR_REL) || (op == OP_JUMP) ||
           (op == OP_CALL) || (op == OP_RET)    || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/pc_sequencer_fsm_if.sv
// Control bundle between the PC sequencer and its neighbours
// (decode logic, instruction memory, address generator).
// master = sequencer side, slave = surrounding datapath side.
interface pc_sequencer_fsm_if;

  logic        fetch_ack;
  logic [2:0]  op_class;
  logic        branch_cond;
  logic        stall;

  logic [1:0]  PC_select;
  logic        INC_select;
  logic        PC_enable;
  logic        PC_Reset;
  logic        fetch_req;
  logic        ir_load;
  logic        link_we;
  logic        halted;
  logic        fetch_err;
  logic [31:0] retire_count;

  modport master (
    input  fetch_ack, op_class, branch_cond, stall,
    output PC_select, INC_select, PC_enable, PC_Reset, fetch_req,
           ir_load, link_we, halted, fetch_err, retire_count
  );

  modport slave (
    output fetch_ack, op_class, branch_cond, stall,
    input  PC_select, INC_select, PC_enable, PC_Reset, fetch_req,
           ir_load, link_we, halted, fetch_err, retire_count
  );

endinterface

// File: rtl/pc_seq_timer.sv
// Loadable down-counter shared by the reset-hold and fetch-timeout paths.
// zero_o flags that the decrement taken this cycle lands on zero, so the
// owning state can leave on the same edge the count expires.
module pc_seq_timer #(
  parameter int CNT_W   = 5,
  parameter int RST_VAL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load has priority, decrement saturates at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Counter register, reset to the reset-hold length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= CNT_W'(RST_VAL);
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q <= CNT_W'(1));

endmodule

// File: rtl/pc_sequencer_fsm.sv
// Multi-cycle PC sequencer: RST hold -> FETCH -> DECODE -> EXEC per
// instruction, driving the address-generator controls.
// Optional build macro: SEQ_RETIRE_CNT_EN enables the retired-instruction
// counter on retire_count; without it retire_count is tied to zero.
module pc_sequencer_fsm
  import pc_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 4,
  parameter int FETCH_TIMEOUT   = 16,
  parameter int CNT_W           = 5
) (
  input  logic               Clock,
  input  logic               Reset_n,
  pc_sequencer_fsm_if.master bus
);

  state_e     state_q;
  state_e     state_d;

  logic [2:0] op_class_q;
  logic       branch_cond_q;
  logic       link_pend_q;
  logic       fetch_err_q;

  logic       tmr_load;
  logic       tmr_dec;
  logic       tmr_zero;
  logic       fetch_timeout;

  logic [1:0] pc_select;
  logic       inc_select;
  logic       pc_enable;
  logic       pc_reset;
  logic       fetch_req;
  logic       ir_load;
  logic       link_we;
  logic       halted;

  // The counter reloads whenever FETCH is entered and counts down while
  // holding reset or waiting for the instruction word.
  assign tmr_load      = (state_d == FETCH) && (state_q != FETCH);
  assign tmr_dec       = (state_q == RST) || (state_q == FETCH);
  assign fetch_timeout = (state_q == FETCH) && !bus.fetch_ack && tmr_zero;

  pc_seq_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (RST_HOLD_CYCLES)
  ) u_timer (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .load_i     (tmr_load),
    .load_val_i (CNT_W'(FETCH_TIMEOUT)),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // State register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; each state only looks at the inputs it owns
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RST: begin
        if (tmr_zero) state_d = FETCH;
      end
      FETCH: begin
        // An ack on the final timeout cycle still counts as a fetch
        if (bus.fetch_ack)  state_d = DECODE;
        else if (tmr_zero)  state_d = HALT;
      end
      DECODE: begin
        state_d = op_is_legal(bus.op_class) ? EXEC : HALT;
      end
      EXEC: begin
        if (!bus.stall) state_d = (op_class_q == OP_HALT) ? HALT : FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RST;
      end
    endcase
  end

  // Output decode from registered state plus the live stall input
  always_comb begin
    pc_select  = PCSEL_NEXT;
    inc_select = 1'b0;
    pc_enable  = 1'b0;
    pc_reset   = 1'b0;
    fetch_req  = 1'b0;
    ir_load    = 1'b0;
    link_we    = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      RST: begin
        pc_reset = 1'b1;
      end
      FETCH: begin
        fetch_req = 1'b1;
        ir_load   = bus.fetch_ack;
        link_we   = link_pend_q;
      end
      DECODE: begin
      end
      EXEC: begin
        pc_enable = !bus.stall && (op_class_q != OP_HALT);
        case (op_class_q)
          OP_BR_REL:        inc_select = branch_cond_q;
          OP_JUMP, OP_CALL: pc_select  = PCSEL_ABS;
          OP_RET:           pc_select  = PCSEL_RA;
          default:          pc_select  = PCSEL_NEXT;
        endcase
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        pc_reset = 1'b1;
      end
    endcase
  end

  // Decode latches, CALL link strobe scheduling and sticky fetch error.
  // link_pend_q is set by the CALL update so link_we lands in the very
  // next FETCH cycle, while PC_temp still holds the pre-update PC.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      op_class_q    <= 3'b000;
      branch_cond_q <= 1'b0;
      link_pend_q   <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      if (state_q == DECODE) begin
        op_class_q    <= bus.op_class;
        branch_cond_q <= bus.branch_cond;
      end
      link_pend_q <= pc_enable && (op_class_q == OP_CALL);
      if (fetch_timeout) fetch_err_q <= 1'b1;
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  logic [31:0] retire_q;

  // Count every EXEC cycle that commits a PC update; wraps naturally
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      retire_q <= 32'd0;
    end else if (pc_enable) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign bus.retire_count = retire_q;
`else
  assign bus.retire_count = 32'd0;
`endif

  assign bus.PC_select  = pc_select;
  assign bus.INC_select = inc_select;
  assign bus.PC_enable  = pc_enable;
  assign bus.PC_Reset   = pc_reset;
  assign bus.fetch_req  = fetch_req;
  assign bus.ir_load    = ir_load;
  assign bus.link_we    = link_we;
  assign bus.halted     = halted;
  assign bus.fetch_err  = fetch_err_q;

endmodule
